// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences PC/IR/regfile/ALU/unified memory and counts retired instructions.
// Latency: 3-5 clocks per instruction; control outputs are registered, branch pc_we is qualified by same-cycle zero.
// Backpressure: none; TRAP holds until reset, and reset gates all write enables combinationally.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_we,
    output logic             ir_we,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             rf_we,
    output logic [1:0]       rf_wa_sel,
    output logic [1:0]       rf_wd_sel,
    output logic             alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       rf_we;
        logic [1:0] rf_wa_sel;
        logic [1:0] rf_wd_sel;
        logic       alu_a_sel;
        logic [1:0] alu_b_sel;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       br_eq;
        logic       br_ne;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        state_t n;
        n = S_TRAP;
        case (s)
            S_FETCH: n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE: begin
                        case (fn)
                            FN_ADD, FN_SUB, FN_SLT: n = S_R_EXEC;
                            FN_JR:                  n = S_JUMP;
                            default:                n = S_TRAP;
                        endcase
                    end
                    OP_LW, OP_SW:     n = S_MEM_ADDR;
                    OP_ADDI, OP_XORI: n = S_I_EXEC;
                    OP_BEQ, OP_BNE:   n = S_BRANCH;
                    OP_J, OP_JAL:     n = S_JUMP;
                    default:          n = S_TRAP;
                endcase
            end
            S_MEM_ADDR: n = (op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: n = S_MEM_WB;
            S_R_EXEC:   n = S_R_WB;
            S_I_EXEC:   n = S_I_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: n = S_FETCH;
            default:    n = S_TRAP;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_we     = 1'b1;
                c.alu_b_sel = 2'd1;
                c.pc_we     = 1'b1;
            end
            S_DECODE: c.alu_b_sel = 2'd3;
            S_MEM_ADDR: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 2'd2;
            end
            S_MEM_READ: c.mem_addr_sel = 1'b1;
            S_MEM_WB: begin
                c.rf_we      = 1'b1;
                c.rf_wd_sel  = 2'd1;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_addr_sel = 1'b1;
                c.mem_we       = 1'b1;
                c.instr_done   = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_a_sel = 1'b1;
                c.alu_op    = (fn == FN_SUB) ? 3'd1 : (fn == FN_SLT) ? 3'd3 : 3'd0;
            end
            S_R_WB: begin
                c.rf_we      = 1'b1;
                c.rf_wa_sel  = 2'd1;
                c.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_a_sel = 1'b1;
                c.alu_b_sel = 2'd2;
                c.alu_op    = (op == OP_XORI) ? 3'd2 : 3'd0;
            end
            S_I_WB: begin
                c.rf_we      = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alu_a_sel  = 1'b1;
                c.alu_op     = 3'd1;
                c.pc_src     = 2'd1;
                c.br_eq      = (op == OP_BEQ);
                c.br_ne      = (op == OP_BNE);
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_we      = 1'b1;
                c.pc_src     = (op == OP_RTYPE) ? 2'd3 : 2'd2;
                c.instr_done = 1'b1;
                // PC already holds PC+4 here, so JAL links straight from the PC
                if (op == OP_JAL) begin
                    c.rf_we     = 1'b1;
                    c.rf_wa_sel = 2'd2;
                    c.rf_wd_sel = 2'd2;
                end
            end
            S_TRAP: c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t           state_q;
    state_t           state_n;
    ctrl_t            ctrl_q;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [5:0]       op_n;
    logic [5:0]       fn_n;
    logic [CNT_W-1:0] cnt_q;

    // Opcode/funct are only trusted at DECODE; afterwards the latched copies steer everything
    always_comb begin
        op_n    = (state_q == S_DECODE) ? opcode : op_q;
        fn_n    = (state_q == S_DECODE) ? funct  : fn_q;
        state_n = next_state(state_q, op_n, fn_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
            ctrl_q  <= decode(S_FETCH, 6'd0, 6'd0);
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            fn_q    <= fn_n;
            ctrl_q  <= decode(state_n, op_n, fn_n);
            if (ctrl_q.instr_done)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_we        = ~reset & (ctrl_q.pc_we | (ctrl_q.br_eq & zero) | (ctrl_q.br_ne & ~zero));
    assign ir_we        = ~reset & ctrl_q.ir_we;
    assign mem_we       = ~reset & ctrl_q.mem_we;
    assign rf_we        = ~reset & ctrl_q.rf_we;
    assign mem_addr_sel = ctrl_q.mem_addr_sel;
    assign rf_wa_sel    = ctrl_q.rf_wa_sel;
    assign rf_wd_sel    = ctrl_q.rf_wd_sel;
    assign alu_a_sel    = ctrl_q.alu_a_sel;
    assign alu_b_sel    = ctrl_q.alu_b_sel;
    assign alu_op       = ctrl_q.alu_op;
    assign pc_src       = ctrl_q.pc_src;
    assign state        = state_q;
    assign instr_done   = ctrl_q.instr_done;
    assign illegal      = ctrl_q.illegal;
    assign instr_count  = cnt_q;

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control FSM that sequences the MIPS datapath (PC, IR, register file, ALU, unified instruction/data memory) over several clocks per instruction.
- It replaces single-cycle combinational decode, so the unified memory and a single ALU are shared between fetch, address and execute phases.
- Sits beside the datapath inside the cpu top level.
- Drives every write enable and mux select, and counts retired instructions so benches can check progress without probing internal registers.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; valid from the DECODE state onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, same cycle.
- pc_we  out  1  PC write enable.
- ir_we  out  1  IR write enable.
- mem_we  out  1  memory write enable.
- mem_addr_sel  out  1  0=PC, 1=ALUOut.
- rf_we  out  1  register file write enable.
- rf_wa_sel  out  2  write address: 0=rt, 1=rd, 2=r31.
- rf_wd_sel  out  2  write data: 0=ALUOut, 1=MDR, 2=PC.
- alu_a_sel  out  1  0=PC, 1=regA.
- alu_b_sel  out  2  0=regB, 1=const 4, 2=sext(imm), 3=sext(imm)<<2.
- alu_op  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT.
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target, 3=regA.
- state  out  4  current state, for debug.
- instr_done  out  1  high during the final state of each instruction.
- illegal  out  1  sticky; set on an unsupported instruction.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Supported instructions:
  - LW 0x23, SW 0x2B, ADDI 0x08, XORI 0x0E, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
  - R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, I_EXEC 8, I_WB 9, BRANCH 10, JUMP 11, TRAP 15.
- Outputs are Moore, decoded from state plus the latched opcode/funct. Any output not listed for a state is 0.
- FETCH:
  - mem_addr_sel=0, ir_we=1, alu_a_sel=0, alu_b_sel=1, ADD, pc_src=0, pc_we=1.
  - Next state: DECODE.
- DECODE:
  - alu_a_sel=0, alu_b_sel=3, ADD (branch target into ALUOut).
  - opcode/funct are latched into internal registers at the end of this cycle.
  - Next state: LW/SW→MEM_ADDR; R-type (non-JR)→R_EXEC; ADDI/XORI→I_EXEC; BEQ/BNE→BRANCH; J/JAL/JR→JUMP; anything else→TRAP.
- MEM_ADDR:
  - alu_a_sel=1, alu_b_sel=2, ADD.
  - Next state: MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_addr_sel=1; next state MEM_WB.
- MEM_WB: rf_we=1, wa=0, wd=1, instr_done; next state FETCH.
- MEM_WRITE: mem_addr_sel=1, mem_we=1, instr_done; next state FETCH.
- R_EXEC: alu_a_sel=1, alu_b_sel=0, alu_op from funct; next state R_WB.
- R_WB: rf_we=1, wa=1, wd=0, instr_done; next state FETCH.
- I_EXEC: alu_a_sel=1, alu_b_sel=2, ADD (ADDI) or XOR (XORI); next state I_WB.
- I_WB: rf_we=1, wa=0, wd=0, instr_done; next state FETCH.
- BRANCH:
  - alu_a_sel=1, alu_b_sel=0, SUB, pc_src=1.
  - pc_we = zero for BEQ, ~zero for BNE.
  - instr_done; next state FETCH.
- JUMP:
  - J: pc_src=2, pc_we=1.
  - JAL: pc_src=2, pc_we=1, rf_we=1, wa=2, wd=2 (PC already holds PC+4).
  - JR: pc_src=3, pc_we=1.
  - instr_done; next state FETCH.
- TRAP:
  - illegal=1, all enables 0, state held.
  - Exited only by reset.
- Latency in clocks: LW 5; SW, R-type, ADDI, XORI 4; branches and jumps 3.
- instr_count:
  - Increments on the rising edge that ends any state with instr_done=1.
  - Wraps modulo 2^CNT_W.
  - Never increments in TRAP.
- Reset:
  - Asynchronous: state=FETCH, latched opcode/funct=0, illegal=0, instr_count=0.
  - While reset is high, pc_we, ir_we, mem_we and rf_we are forced 0 combinationally, overriding the FETCH decode.
  - Reset asserted mid-instruction aborts immediately with no further writes.
  - Execution begins in FETCH on the first rising edge after reset deasserts.

Test Plan:
- Reset high for 3 clocks → state=0, all enables 0, instr_count=0, illegal=0. Release → next cycle ir_we=1, pc_we=1.
- opcode=0x23 → states 0,1,2,3,4,0. In state 4: rf_we=1, wa_sel=0, wd_sel=1. instr_count=1 after 5 edges.
- opcode=0x04 with zero=0 → BRANCH with pc_we=0. opcode=0x05 with zero=0 → pc_we=1, pc_src=1. Both take 3 clocks.
- opcode=0x00, funct=0x2A → R_EXEC alu_op=011, R_WB wa_sel=1. opcode=0x03 → JUMP with rf_we=1, wa_sel=2, wd_sel=2, pc_src=2.
- opcode=0x3F → TRAP; illegal=1 and all enables 0 for 10 clocks; instr_count unchanged. Reset → illegal=0, state=0.
- Reset asserted while in MEM_READ of an LW → enables drop in the same cycle, no rf_we pulse. After release: FETCH, instr_count=0.
